// File: rtl/sdram_write_ctrl.sv
// ---------------------------------------------------------------------------
// sdram_write_ctrl
//   SDRAM write-path engine sharing the command bus with the read engine.
//   A write_trig pulse in S_IDLE starts one job of BURST_TIMES 4-word bursts.
//   The engine requests the bus, ACTIVEs the current row, then issues
//   back-to-back BL=4 WRITEs fed from a show-ahead FIFO. It precharges at
//   row end, on a pending refresh or at job end. Addresses advance linearly
//   col -> row -> bank and persist across jobs.
//
// Optional feature (macro WR_PINGPONG_EN):
//   defined   : bank toggles 0 <-> 1 only, and write_bank_addr exports the
//               current bank so the reader can use the other one.
//   undefined : bank advances (bank+1) mod 4 and write_bank_addr is absent.
//
// Ports
//   sysclk_100M      in   system clock, single domain
//   rst_n            in   synchronous active-low reset
//   write_trig       in   start one job (sampled only in S_IDLE)
//   wr_data          in   FIFO head word (show-ahead)
//   wr_data_req      out  FIFO pop, high for every S_WRITE cycle
//   refresh_req      in   refresh pending: yield at the next burst boundary
//   arbit_write_req  out  bus request to the arbiter
//   arbit_write_ack  in   bus grant
//   arbit_write_end  out  job complete / engine idle
//   arbit_prech_end  out  1-cycle pulse after a precharge completes
//   cmd_reg          out  {CS,RAS,CAS,WE}
//   sdram_addr       out  row / column / A10 address
//   sdram_bank_addr  out  bank address
//   sdram_dq_out     out  write data, aligned with cmd_reg
//   sdram_dq_oe      out  DQ output enable
//   write_bank_addr  out  current bank (WR_PINGPONG_EN only)
// ---------------------------------------------------------------------------
module sdram_write_ctrl #(
  parameter int BURST_TIMES  = 64,
  parameter int ROW_ADDR_END = 8192,
  parameter int COL_ADDR_END = 512,
  parameter int DATA_W       = 16
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              write_trig,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_req,
  input  logic              refresh_req,
  output logic              arbit_write_req,
  input  logic              arbit_write_ack,
  output logic              arbit_write_end,
  output logic              arbit_prech_end,
  output logic [3:0]        cmd_reg,
  output logic [12:0]       sdram_addr,
  output logic [1:0]        sdram_bank_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
`ifdef WR_PINGPONG_EN
  ,
  output logic [1:0]        write_bank_addr
`endif
);

  localparam logic [3:0]  CMD_ACT   = 4'b0011;
  localparam logic [3:0]  CMD_WRITE = 4'b0100;
  localparam logic [3:0]  CMD_PRECH = 4'b0010;
  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [12:0] ADDR_A10  = 13'h0400;
  localparam logic [8:0]  LAST_COL  = 9'(COL_ADDR_END - 4);
  localparam logic [12:0] LAST_ROW  = 13'(ROW_ADDR_END - 1);
  localparam int          BCNT_W    = $clog2(BURST_TIMES + 1);
  localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(BURST_TIMES - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACT, S_WRITE, S_PRECH} state_t;

  state_t            state, state_next;
  logic [1:0]        cnt;         // step counter inside ACT / WRITE / PRECH
  logic [8:0]        col;
  logic [12:0]       row;
  logic [1:0]        bank, bank_next;
  logic [BCNT_W-1:0] burst_cnt;
  logic              burst_done;  // last burst of the job has been written
  logic              row_end;     // current slot is the last column slot of the row
  logic              slot_end;
  logic              last_burst;

`ifdef WR_PINGPONG_EN
  assign bank_next       = {1'b0, ~bank[0]};
  assign write_bank_addr = bank;
`else
  assign bank_next = (bank == 2'd3) ? 2'd0 : bank + 2'd1;
`endif

  assign wr_data_req = (state == S_WRITE);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_next = state;
    slot_end   = (state == S_WRITE) && (cnt == 2'd3);
    last_burst = (burst_cnt == LAST_BURST);
    unique case (state)
      S_IDLE:  if (write_trig) state_next = S_REQ;
      S_REQ:   if (arbit_write_ack) state_next = S_ACT;
      S_ACT:   if (cnt == 2'd1) state_next = S_WRITE;
      S_WRITE: if (slot_end && (last_burst || refresh_req || row_end)) state_next = S_PRECH;
      S_PRECH: if (cnt == 2'd3) begin
        // Job end wins over refresh: the arbiter regains the bus either way.
        if (burst_done)       state_next = S_IDLE;
        else if (refresh_req) state_next = S_REQ;
        else                  state_next = S_ACT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sysclk_100M) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      col             <= '0;
      row             <= '0;
      bank            <= '0;
      burst_cnt       <= '0;
      burst_done      <= 1'b0;
      row_end         <= 1'b0;
      arbit_write_req <= 1'b0;
      arbit_write_end <= 1'b1;
      arbit_prech_end <= 1'b0;
      cmd_reg         <= CMD_NOP;
      sdram_addr      <= ADDR_A10;
      sdram_bank_addr <= '0;
      sdram_dq_out    <= '0;
      sdram_dq_oe     <= 1'b0;
    end else begin
      state <= state_next;
      // Restart at 0 on every state change; inside S_WRITE the 2-bit wrap
      // 3 -> 0 is the back-to-back slot loop.
      if (state_next != state || state == S_IDLE || state == S_REQ) cnt <= '0;
      else                                                          cnt <= cnt + 2'd1;

      // Request drops on the grant edge so it never lingers into S_ACT.
      arbit_write_req <= (state == S_REQ) && (state_next == S_REQ);
      arbit_prech_end <= (state == S_PRECH) && (cnt == 2'd3);

      if (state != S_ACT && state_next == S_ACT) arbit_write_end <= 1'b0;

      if (state == S_WRITE && cnt == 2'd0 && col == LAST_COL) row_end <= 1'b1;
      else if (state == S_ACT)                                 row_end <= 1'b0;

      if (state == S_PRECH && cnt == 2'd3) burst_done <= 1'b0;

      if (slot_end) begin
        if (last_burst) begin
          burst_cnt       <= '0;
          burst_done      <= 1'b1;
          arbit_write_end <= 1'b1;
        end else begin
          burst_cnt <= burst_cnt + 1'b1;
        end
        if (row_end) begin
          col <= '0;
          if (row == LAST_ROW) begin
            row  <= '0;
            bank <= bank_next;
          end else begin
            row <= row + 13'd1;
          end
        end else begin
          col <= col + 9'd4;
        end
      end

      // Command/address/data are registered from the current state/counters.
      cmd_reg         <= CMD_NOP;
      sdram_addr      <= ADDR_A10;
      sdram_bank_addr <= bank;
      sdram_dq_oe     <= 1'b0;
      unique case (state)
        S_ACT: if (cnt == 2'd0) begin
          cmd_reg    <= CMD_ACT;
          sdram_addr <= row;
        end
        S_WRITE: begin
          if (cnt == 2'd0) begin
            cmd_reg    <= CMD_WRITE;
            sdram_addr <= {4'b0, col};
          end
          sdram_dq_out <= wr_data;
          sdram_dq_oe  <= 1'b1;
        end
        S_PRECH: if (cnt == 2'd2) cmd_reg <= CMD_PRECH;  // A10=1: all banks
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdram_write_ctrl
//   Self-checking bench for sdram_write_ctrl with small geometry
//   (2 bursts per job, 5 column slots per row, 3 rows per bank) so row and
//   bank wraps happen within a short run. The bench acts as FIFO and arbiter.
//   Expected command streams come from a transaction-level model: a linear
//   slot index mapped to col/row/bank by arithmetic.
// ---------------------------------------------------------------------------
module tb_sdram_write_ctrl;

  localparam int B   = 2;
  localparam int C   = 20;
  localparam int R   = 3;
  localparam int DW  = 16;
  localparam int SPR = C / 4;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  bank;
  } cmd_t;

  typedef struct {
    int ack_delay;
    int rslot;
    int exp_row;
    int exp_col;
    int exp_bank;
    int exp_nprech;
    int exp_last_bank;
  } vec_t;

  logic          sysclk_100M = 1'b0;
  logic          rst_n;
  logic          write_trig;
  logic [DW-1:0] wr_data;
  logic          wr_data_req;
  logic          refresh_req;
  logic          arbit_write_req;
  logic          arbit_write_ack;
  logic          arbit_write_end;
  logic          arbit_prech_end;
  logic [3:0]    cmd_reg;
  logic [12:0]   sdram_addr;
  logic [1:0]    sdram_bank_addr;
  logic [DW-1:0] sdram_dq_out;
  logic          sdram_dq_oe;
`ifdef WR_PINGPONG_EN
  logic [1:0]    write_bank_addr;
`endif

  sdram_write_ctrl #(
    .BURST_TIMES (B),
    .ROW_ADDR_END(R),
    .COL_ADDR_END(C),
    .DATA_W      (DW)
  ) dut (
    .sysclk_100M    (sysclk_100M),
    .rst_n          (rst_n),
    .write_trig     (write_trig),
    .wr_data        (wr_data),
    .wr_data_req    (wr_data_req),
    .refresh_req    (refresh_req),
    .arbit_write_req(arbit_write_req),
    .arbit_write_ack(arbit_write_ack),
    .arbit_write_end(arbit_write_end),
    .arbit_prech_end(arbit_prech_end),
    .cmd_reg        (cmd_reg),
    .sdram_addr     (sdram_addr),
    .sdram_bank_addr(sdram_bank_addr),
    .sdram_dq_out   (sdram_dq_out),
    .sdram_dq_oe    (sdram_dq_oe)
`ifdef WR_PINGPONG_EN
    ,
    .write_bank_addr(write_bank_addr)
`endif
  );

  always #5 sysclk_100M = ~sysclk_100M;

  int          checks   = 0;
  int          failures = 0;
  int          cycle    = 0;
  int          m_lin    = 0;
  int unsigned head     = 0;
  logic [DW-1:0] words[1024];
  cmd_t          got_cmds[$];
  cmd_t          exp_cmds[$];
  logic [DW-1:0] got_data[$];
  logic [DW-1:0] exp_data[$];
  vec_t          vecs[8];

  // Show-ahead FIFO: head word visible, popped on every wr_data_req cycle.
  assign wr_data = words[head % 1024];
  always @(posedge sysclk_100M) begin
    cycle <= cycle + 1;
    if (wr_data_req) head <= head + 1;
  end

  // Bus monitor: every non-NOP command and every driven data word.
  always @(negedge sysclk_100M) begin
    if (rst_n === 1'b1) begin
      if (cmd_reg !== NOP) got_cmds.push_back('{cmd_reg, sdram_addr, sdram_bank_addr});
      if (sdram_dq_oe === 1'b1) got_data.push_back(sdram_dq_out);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Linear slot index -> address, straight from the col->row->bank order.
  function automatic void addr_of(input int lin, output int c, output int r, output int b);
    c = (lin % SPR) * 4;
    r = (lin / SPR) % R;
`ifdef WR_PINGPONG_EN
    b = (lin / (SPR * R)) % 2;
`else
    b = (lin / (SPR * R)) % 4;
`endif
  endfunction

  task automatic run_job(input int ack_delay, input int rslot);
    int   writes_seen, req_cycles, t_trig, t_act, t_wr, c, r, b, n;
    int unsigned head0;
    bit   done, rend;
    cmd_t e;
    exp_cmds.delete();
    exp_data.delete();
    head0 = head;
    addr_of(m_lin, c, r, b);
    e = '{ACT, 13'(r), 2'(b)};
    exp_cmds.push_back(e);
    for (int s = 0; s < B; s++) begin
      addr_of(m_lin, c, r, b);
      e = '{WR, 13'(c), 2'(b)};
      exp_cmds.push_back(e);
      for (int k = 0; k < 4; k++) exp_data.push_back(words[(head0 + 4 * s + k) % 1024]);
      rend = ((m_lin % SPR) == SPR - 1);
      m_lin++;
      if (s == B - 1) begin
        e = '{PRE, 13'h0400, 2'b0};
        exp_cmds.push_back(e);
      end else if (rend || s == rslot) begin
        e = '{PRE, 13'h0400, 2'b0};
        exp_cmds.push_back(e);
        addr_of(m_lin, c, r, b);
        e = '{ACT, 13'(r), 2'(b)};
        exp_cmds.push_back(e);
      end
    end

    got_cmds.delete();
    got_data.delete();
    @(negedge sysclk_100M);
    write_trig = 1'b1;
    t_trig     = cycle;
    @(negedge sysclk_100M);
    write_trig  = 1'b0;
    writes_seen = 0;
    req_cycles  = 0;
    t_act       = -1;
    t_wr        = -1;
    done        = 1'b0;
    for (int budget = 0; budget < 400 && !done; budget++) begin
      if (arbit_write_req) req_cycles++;
      else                 req_cycles = 0;
      arbit_write_ack = arbit_write_req && (req_cycles > ack_delay);
      if (cmd_reg == ACT && t_act < 0) begin
        t_act = cycle;
        check("end_low_after_act", arbit_write_end, 1'b0);
`ifdef WR_PINGPONG_EN
        check("write_bank_addr", write_bank_addr, exp_cmds[0].bank);
`endif
      end
      if (cmd_reg == WR) begin
        writes_seen++;
        if (t_wr < 0) t_wr = cycle;
        check("dq_oe_with_write", sdram_dq_oe, 1'b1);
        if (writes_seen == rslot + 1) refresh_req = 1'b1;
      end
      if (arbit_prech_end) refresh_req = 1'b0;
      if (arbit_prech_end && writes_seen == B) done = 1'b1;
      // Stray triggers mid-job must be ignored.
      write_trig = (writes_seen > 0 && writes_seen < B && $urandom_range(0, 3) == 0);
      if (!done) @(negedge sysclk_100M);
    end
    check("job_done", done, 1'b1);
    write_trig      = 1'b0;
    refresh_req     = 1'b0;
    arbit_write_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge sysclk_100M);
      check("req_low_after_job", arbit_write_req, 1'b0);
      check("cmd_nop_after_job", cmd_reg, NOP);
    end
    check("end_high_after_job", arbit_write_end, 1'b1);
    check("lat_trig_to_act", t_act - t_trig, ack_delay + 4);
    check("lat_act_to_write", t_wr - t_act, 2);

    check("num_cmds", got_cmds.size(), exp_cmds.size());
    n = (got_cmds.size() < exp_cmds.size()) ? got_cmds.size() : exp_cmds.size();
    for (int i = 0; i < n; i++) begin
      check("cmd", got_cmds[i].cmd, exp_cmds[i].cmd);
      check("cmd_addr", got_cmds[i].addr, exp_cmds[i].addr);
      if (exp_cmds[i].cmd != PRE) check("cmd_bank", got_cmds[i].bank, exp_cmds[i].bank);
    end
    check("num_words", got_data.size(), exp_data.size());
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) check("dq_word", got_data[i], exp_data[i]);
  endtask

  initial begin
    int   nprech, last_bank, rslot;
    bit   hit;
    rst_n           = 1'b0;
    write_trig      = 1'b0;
    refresh_req     = 1'b0;
    arbit_write_ack = 1'b0;
    for (int i = 0; i < 1024; i++) words[i] = 16'($urandom);

    // Directed jobs: {ack_delay, refresh slot, first row, first col, bank,
    // precharges, bank of last write}.
    vecs[0] = '{2, -1, 0,  0, 0, 1, 0};
    vecs[1] = '{0,  0, 0,  8, 0, 2, 0};
    vecs[2] = '{1,  1, 0, 16, 0, 2, 0};  // row end, refresh with job end
    vecs[3] = '{3, -1, 1,  4, 0, 1, 0};
    vecs[4] = '{0,  0, 1, 12, 0, 2, 0};
    vecs[5] = '{2, -1, 2,  0, 0, 1, 0};
    vecs[6] = '{1,  1, 2,  8, 0, 1, 0};
    vecs[7] = '{0, -1, 2, 16, 0, 2, 1};  // last row/col slot: bank 0 -> 1

    // Reset values.
    repeat (2) @(posedge sysclk_100M);
    @(negedge sysclk_100M);
    check("rst_cmd", cmd_reg, NOP);
    check("rst_addr", sdram_addr, 13'h0400);
    check("rst_bank", sdram_bank_addr, 2'd0);
    check("rst_write_end", arbit_write_end, 1'b1);
    check("rst_req", arbit_write_req, 1'b0);
    check("rst_prech_end", arbit_prech_end, 1'b0);
    check("rst_dq_oe", sdram_dq_oe, 1'b0);
    check("rst_dq_out", sdram_dq_out, 16'h0);
    check("rst_fifo_pop", wr_data_req, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk_100M);

    for (int j = 0; j < 8; j++) begin
      run_job(vecs[j].ack_delay, vecs[j].rslot);
      nprech    = 0;
      last_bank = -1;
      foreach (got_cmds[i]) begin
        if (got_cmds[i].cmd == PRE) nprech++;
        if (got_cmds[i].cmd == WR)  last_bank = int'(got_cmds[i].bank);
      end
      check("tbl_first_row", got_cmds.size() > 0 ? got_cmds[0].addr : 13'h1fff, vecs[j].exp_row);
      check("tbl_first_col", got_cmds.size() > 1 ? got_cmds[1].addr : 13'h1fff, vecs[j].exp_col);
      check("tbl_first_bank", got_cmds.size() > 1 ? got_cmds[1].bank : 2'd3, vecs[j].exp_bank);
      check("tbl_num_prech", nprech, vecs[j].exp_nprech);
      check("tbl_last_bank", last_bank, vecs[j].exp_last_bank);
    end

    // Randomized jobs against the model; crosses further row and bank wraps.
    for (int j = 0; j < 24; j++) begin
      rslot = int'($urandom_range(0, 3));
      if (rslot >= B) rslot = -1;
      run_job(int'($urandom_range(0, 4)), rslot);
    end

    // Reset in the middle of a write slot.
    @(negedge sysclk_100M);
    write_trig = 1'b1;
    @(negedge sysclk_100M);
    write_trig = 1'b0;
    hit = 1'b0;
    for (int budget = 0; budget < 60 && !hit; budget++) begin
      arbit_write_ack = arbit_write_req;
      if (cmd_reg == WR) hit = 1'b1;
      else               @(negedge sysclk_100M);
    end
    check("midjob_write_seen", hit, 1'b1);
    rst_n           = 1'b0;
    arbit_write_ack = 1'b0;
    @(negedge sysclk_100M);
    check("midrst_cmd", cmd_reg, NOP);
    check("midrst_dq_oe", sdram_dq_oe, 1'b0);
    check("midrst_addr", sdram_addr, 13'h0400);
    check("midrst_req", arbit_write_req, 1'b0);
    check("midrst_write_end", arbit_write_end, 1'b1);
    check("midrst_idle", wr_data_req, 1'b0);
    @(negedge sysclk_100M);
    rst_n = 1'b1;
    m_lin = 0;
    @(negedge sysclk_100M);
    run_job(1, -1);
    check("restart_row", got_cmds.size() > 0 ? got_cmds[0].addr : 13'h1fff, 13'd0);
    check("restart_col", got_cmds.size() > 1 ? got_cmds[1].addr : 13'h1fff, 13'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
